// File: rtl/core_pkg.sv
// core_pkg: shared pipeline-control state encoding and forwarding select codes
package core_pkg;
  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_e;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
endpackage

// File: rtl/hazard_sequencer_fwd_select.sv
// fwd_select: combinational ALU operand forward selector (M over W, x0 never forwards)
module fwd_select
  import core_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       we_m,
  input  logic       we_w,
  output logic [1:0] fwd
);
  // the younger producer in memory wins over writeback
  always_comb
    fwd = (we_m && rd_m != 5'd0 && rd_m == rs) ? FWD_M :
          (we_w && rd_w != 5'd0 && rd_w == rs) ? FWD_W : FWD_RF;
endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/flush/forward control for the 5-stage core; HZD_PERF_CNT_EN adds perf counters
module hazard_sequencer
  import core_pkg::*;
#(
  parameter int STARTUP_CYCLES = 4,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             ResultSrcE0,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             pcsrc,
  input  logic             mem_busy,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int SW = $clog2(STARTUP_CYCLES + 2);
  localparam int TW = $clog2(MEM_TIMEOUT + 2);
  state_e        state_q, state_d;
  logic [SW-1:0] init_cnt_q, init_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          lu, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, br_flush;
  logic [1:0]    fwd_a, fwd_b;
  logic          fwd_en;

  fwd_select u_fwd_a (.rs(Rs1E), .rd_m(RdM), .rd_w(RdW), .we_m(RegWriteM), .we_w(RegWriteW), .fwd(fwd_a));
  fwd_select u_fwd_b (.rs(Rs2E), .rd_m(RdM), .rd_w(RdW), .we_m(RegWriteM), .we_w(RegWriteW), .fwd(fwd_b));

  assign lu     = ResultSrcE0 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
  assign fwd_en = rst && state_q != INIT;

  // state, startup counter and memory timeout counter
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      tmo_q      <= tmo_d;
    end

  // next state and raw pipeline controls; memory stall outranks load-use, which outranks branch flush
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    tmo_d      = tmo_q;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    br_flush   = 1'b0;
    case (state_q)
      INIT: begin
        stall_f    = 1'b1;
        flush_d    = 1'b1;
        flush_e    = 1'b1;
        init_cnt_d = init_cnt_q + SW'(1);
        state_d    = (32'(init_cnt_q) + 32'd1 >= 32'(STARTUP_CYCLES)) ? RUN : INIT;
      end
      RUN, MEM_WAIT: begin
        if (mem_busy) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          tmo_d   = (state_q == RUN) ? TW'(1) : tmo_q + TW'(1);
          state_d = (state_q == MEM_WAIT && 32'(tmo_q) + 32'd1 >= 32'(MEM_TIMEOUT)) ? ERROR : MEM_WAIT;
        end else begin
          state_d  = RUN;
          stall_f  = lu;
          stall_d  = lu;
          flush_e  = lu;
          br_flush = pcsrc && !lu;
          flush_d  = br_flush;
        end
      end
      default: {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
    endcase
  end

  assign {StallF, StallD, StallE, StallM} = rst ? {stall_f, stall_d, stall_e, stall_m} : 4'b0000;
  assign {FlushD, FlushE}                 = rst ? {flush_d, flush_e} : 2'b00;
  assign ForwardAE                        = fwd_en ? fwd_a : FWD_RF;
  assign ForwardBE                        = fwd_en ? fwd_b : FWD_RF;
  assign mem_err                          = state_q == ERROR;

`ifdef HZD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, lu_cnt_q, lu_cnt_d, flush_cnt_q, flush_cnt_d;

  // saturating event counts; a load-use bubble stalls F/D but not M
  always_comb begin
    stall_cnt_d = (stall_f && state_q != INIT && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    lu_cnt_d    = (stall_d && !stall_m && lu_cnt_q != '1) ? lu_cnt_q + CNT_W'(1) : lu_cnt_q;
    flush_cnt_d = (br_flush && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // performance counter registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stall_cnt_q <= '0;
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end

  assign stall_cnt = stall_cnt_q;
  assign lu_cnt    = lu_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign lu_cnt    = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed scoreboard bench; second instance uses MEM_TIMEOUT=8
module tb_hazard_sequencer;
`ifdef HZD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        ResultSrcE0, RegWriteM, RegWriteW, pcsrc, mem_busy;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, mem_err;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] stall_cnt, lu_cnt, flush_cnt;
  logic        t_StallF, t_StallD, t_StallE, t_StallM, t_FlushD, t_FlushE, t_mem_err;
  logic [1:0]  t_ForwardAE, t_ForwardBE;
  logic [31:0] t_stall_cnt, t_lu_cnt, t_flush_cnt;
  exp_t        q[$];
  int          m[6];
  int          n_assert = 0;
  int          n_fail = 0;

  hazard_sequencer dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .pcsrc(pcsrc), .mem_busy(mem_busy),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .lu_cnt(lu_cnt), .flush_cnt(flush_cnt)
  );

  hazard_sequencer #(.MEM_TIMEOUT(8)) dut_t (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .pcsrc(pcsrc), .mem_busy(mem_busy),
    .StallF(t_StallF), .StallD(t_StallD), .StallE(t_StallE), .StallM(t_StallM),
    .FlushD(t_FlushD), .FlushE(t_FlushE), .ForwardAE(t_ForwardAE), .ForwardBE(t_ForwardBE),
    .mem_err(t_mem_err), .stall_cnt(t_stall_cnt), .lu_cnt(t_lu_cnt), .flush_cnt(t_flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] v(input logic [3:0] st, input logic [1:0] fl,
                                    input logic [1:0] fa, input logic [1:0] fb, input logic err);
    return {st, fl, fa, fb, err};
  endfunction

  function automatic logic [31:0] obs(input int k);
    case (k)
      0: obs = {21'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE, mem_err};
      1: obs = {21'd0, t_StallF, t_StallD, t_StallE, t_StallM, t_FlushD, t_FlushE, t_ForwardAE, t_ForwardBE, t_mem_err};
      2: obs = stall_cnt;
      3: obs = lu_cnt;
      4: obs = flush_cnt;
      5: obs = t_stall_cnt;
      6: obs = t_lu_cnt;
      7: obs = t_flush_cnt;
      default: obs = 'x;
    endcase
  endfunction

  task automatic clr();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {ResultSrcE0, RegWriteM, RegWriteW, pcsrc, mem_busy} = '0;
  endtask

  task automatic push_all(input string tag, input logic [10:0] e, input logic [10:0] et);
    q.push_back('{tag, 0, 32'(e)});
    q.push_back('{{tag, "_t"}, 1, 32'(et)});
    for (int i = 0; i < 6; i++)
      q.push_back('{$sformatf("%s_cnt%0d", tag, i), i + 2, PERF ? 32'(m[i]) : 32'd0});
  endtask

  task automatic drain();
    exp_t        s;
    logic [31:0] o;
    while (q.size() > 0) begin
      s = q.pop_front();
      o = obs(s.kind);
      n_assert++;
      assert (o === s.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", s.tag, o, s.val);
      end
    end
  endtask

  task automatic step(input string tag, input logic [10:0] e, input logic [10:0] et, input bit init);
    push_all(tag, e, et);
    @(negedge clk);
    drain();
    if (!init) begin
      m[0] += int'(e[10]);
      m[2] += int'(e[6]);
      m[3] += int'(et[10]);
      m[5] += int'(et[6]);
    end
    m[1] += int'(e[9] && !e[7]);
    m[4] += int'(et[9] && !et[7]);
    @(posedge clk);
    #1;
  endtask

  logic [10:0] init_v, lu_v, busy_v, err_v;

  initial begin
    init_v = v(4'b1000, 2'b11, 2'b00, 2'b00, 1'b0);
    lu_v   = v(4'b1100, 2'b01, 2'b00, 2'b00, 1'b0);
    busy_v = v(4'b1111, 2'b00, 2'b10, 2'b00, 1'b0);
    err_v  = v(4'b1111, 2'b00, 2'b10, 2'b00, 1'b1);
    for (int i = 0; i < 6; i++) m[i] = 0;
    clr();
    #3;
    push_all("reset", 11'd0, 11'd0);
    drain();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("init%0d", i), init_v, init_v, 1'b1);
    step("run_idle", 11'd0, 11'd0, 1'b0);
    ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    step("lu_rs1", lu_v, lu_v, 1'b0);
    clr();
    step("lu_done", 11'd0, 11'd0, 1'b0);
    ResultSrcE0 = 1'b1; RdE = 5'd9; Rs2D = 5'd9;
    step("lu_rs2", lu_v, lu_v, 1'b0);
    clr();
    ResultSrcE0 = 1'b1;
    step("lu_x0", 11'd0, 11'd0, 1'b0);
    ResultSrcE0 = 1'b0; RdE = 5'd5; Rs1D = 5'd5;
    step("no_load", 11'd0, 11'd0, 1'b0);
    clr();
    RdM = 5'd3; RdW = 5'd3; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs1E = 5'd3;
    step("fwd_a_m", v(4'b0, 2'b0, 2'b10, 2'b00, 1'b0), v(4'b0, 2'b0, 2'b10, 2'b00, 1'b0), 1'b0);
    RegWriteM = 1'b0;
    step("fwd_a_w", v(4'b0, 2'b0, 2'b01, 2'b00, 1'b0), v(4'b0, 2'b0, 2'b01, 2'b00, 1'b0), 1'b0);
    RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0;
    step("fwd_x0", 11'd0, 11'd0, 1'b0);
    RdM = 5'd6; RdW = 5'd7; Rs2E = 5'd7;
    step("fwd_b_w", v(4'b0, 2'b0, 2'b00, 2'b01, 1'b0), v(4'b0, 2'b0, 2'b00, 2'b01, 1'b0), 1'b0);
    Rs2E = 5'd6;
    step("fwd_b_m", v(4'b0, 2'b0, 2'b00, 2'b10, 1'b0), v(4'b0, 2'b0, 2'b00, 2'b10, 1'b0), 1'b0);
    clr();
    pcsrc = 1'b1;
    step("br_flush", v(4'b0, 2'b10, 2'b00, 2'b00, 1'b0), v(4'b0, 2'b10, 2'b00, 2'b00, 1'b0), 1'b0);
    ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    step("br_vs_lu", lu_v, lu_v, 1'b0);
    clr();
    RdM = 5'd4; RegWriteM = 1'b1; Rs1E = 5'd4; mem_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5; end
      step($sformatf("busy%0d", i), busy_v, (i < 8) ? busy_v : err_v, 1'b0);
    end
    mem_busy = 1'b0;
    step("busy_release_lu", v(4'b1100, 2'b01, 2'b10, 2'b00, 1'b0), err_v, 1'b0);
    ResultSrcE0 = 1'b0; RdE = 5'd0; Rs1D = 5'd0;
    step("after_busy", v(4'b0, 2'b0, 2'b10, 2'b00, 1'b0), err_v, 1'b0);
    clr();
    step("err_sticky", 11'd0, v(4'b1111, 2'b00, 2'b00, 2'b00, 1'b1), 1'b0);
    mem_busy = 1'b1;
    step("wait0", v(4'b1111, 2'b0, 2'b0, 2'b0, 1'b0), v(4'b1111, 2'b0, 2'b0, 2'b0, 1'b1), 1'b0);
    step("wait1", v(4'b1111, 2'b0, 2'b0, 2'b0, 1'b0), v(4'b1111, 2'b0, 2'b0, 2'b0, 1'b1), 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) m[i] = 0;
    #1;
    push_all("rst_mid_wait", 11'd0, 11'd0);
    drain();
    mem_busy = 1'b0;
    step("in_reset", 11'd0, 11'd0, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("reinit%0d", i), init_v, init_v, 1'b1);
    step("rerun", 11'd0, 11'd0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
